// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: run/halt state, load-use stall and branch flush sequencing.
// Optional performance counters are enabled by defining HAZARD_PERF_EN.
module hazard_stall_ctrl #(
  parameter int LOAD_STALL_CYCLES   = 1,
  parameter int BRANCH_FLUSH_CYCLES = 1,
  parameter int CNT_W               = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [4:0]  ID_rs_i,
  input  logic [4:0]  ID_rt_i,
  input  logic        ID_uses_rt_i,
  input  logic        EX_MemRead_i,
  input  logic [4:0]  EX_rt_i,
  input  logic        branch_taken_i,
  output logic        PCWrite_o,
  output logic        IF_ID_Write_o,
  output logic        IF_ID_Flush_o,
  output logic        ID_EX_Bubble_o,
  output logic [1:0]  state_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STALL = 2'b10,
    ST_FLUSH = 2'b11
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hz;

  // r0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign hz = EX_MemRead_i && (EX_rt_i != 5'd0) &&
              ((EX_rt_i == ID_rs_i) || (ID_uses_rt_i && (EX_rt_i == ID_rt_i)));

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      state_q <= ST_HALT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first (the halted controls) so no latch is inferred.
    state_d        = state_q;
    cnt_d          = cnt_q;
    PCWrite_o      = 1'b0;
    IF_ID_Write_o  = 1'b0;
    IF_ID_Flush_o  = 1'b0;
    ID_EX_Bubble_o = 1'b1;

    case (state_q)
      ST_HALT: begin
        if (start_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!start_i) begin
          state_d = ST_HALT;
        end else if (hz) begin
          if (LOAD_STALL_CYCLES > 1) begin
            state_d = ST_STALL;
            cnt_d   = CNT_W'(LOAD_STALL_CYCLES - 1);
          end
        end else begin
          PCWrite_o      = 1'b1;
          IF_ID_Write_o  = 1'b1;
          ID_EX_Bubble_o = 1'b0;
          if (branch_taken_i) begin
            IF_ID_Flush_o = 1'b1;
            if (BRANCH_FLUSH_CYCLES > 1) begin
              state_d = ST_FLUSH;
              cnt_d   = CNT_W'(BRANCH_FLUSH_CYCLES - 1);
            end
          end
        end
      end
      ST_STALL, ST_FLUSH: begin
        if (!start_i) begin
          // Pausing abandons the pending sequence; a live hazard is re-detected on resume.
          state_d = ST_HALT;
          cnt_d   = '0;
        end else begin
          if (state_q == ST_FLUSH) begin
            PCWrite_o      = 1'b1;
            IF_ID_Write_o  = 1'b1;
            IF_ID_Flush_o  = 1'b1;
            ID_EX_Bubble_o = 1'b0;
          end
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  assign state_o = state_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;
  logic        stall_inc, flush_inc;

  // Halted cycles also raise the bubble, but they are not hazard stalls.
  assign stall_inc = ID_EX_Bubble_o && start_i &&
                     ((state_q == ST_RUN) || (state_q == ST_STALL));
  assign flush_inc = IF_ID_Flush_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_inc && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_inc && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = 32'd0;
  assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed vector table, a short hand sequence,
// and randomized traffic compared against a cycle-count reference model.
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, uses_rt, memrd, br;
  logic [4:0]  rs, rt, ex_rt;

  logic        pcw0, ifw0, fl0, bub0, pcw1, ifw1, fl1, bub1;
  logic [1:0]  st0, st1;
  logic [31:0] sc0, fc0, sc1, fc1;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.LOAD_STALL_CYCLES(3), .BRANCH_FLUSH_CYCLES(2), .CNT_W(4)) dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .ID_rs_i(rs), .ID_rt_i(rt),
    .ID_uses_rt_i(uses_rt), .EX_MemRead_i(memrd), .EX_rt_i(ex_rt), .branch_taken_i(br),
    .PCWrite_o(pcw0), .IF_ID_Write_o(ifw0), .IF_ID_Flush_o(fl0), .ID_EX_Bubble_o(bub0),
    .state_o(st0), .stall_cnt_o(sc0), .flush_cnt_o(fc0));

  hazard_stall_ctrl #(.LOAD_STALL_CYCLES(1), .BRANCH_FLUSH_CYCLES(1), .CNT_W(4)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .ID_rs_i(rs), .ID_rt_i(rt),
    .ID_uses_rt_i(uses_rt), .EX_MemRead_i(memrd), .EX_rt_i(ex_rt), .branch_taken_i(br),
    .PCWrite_o(pcw1), .IF_ID_Write_o(ifw1), .IF_ID_Flush_o(fl1), .ID_EX_Bubble_o(bub1),
    .state_o(st1), .stall_cnt_o(sc1), .flush_cnt_o(fc1));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: a running flag plus remaining bubble / flush cycle counts.
  localparam logic [3:0] C_HALT = 4'b0001, C_RUN = 4'b1100, C_STALL = 4'b0001, C_FLUSH = 4'b1110;
  int          m_lstall [2] = '{3, 1};
  int          m_bflush [2] = '{2, 1};
  bit          m_run    [2];
  int          m_bub    [2];
  int          m_fl     [2];
  longint      m_sc     [2];
  longint      m_fc     [2];

  function automatic bit hazard();
    return memrd && (ex_rt != 0) && ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));
  endfunction

  function automatic logic [1:0] m_state(int d);
    if (!m_run[d])     return 2'd0;
    if (m_bub[d] > 0)  return 2'd2;
    if (m_fl[d] > 0)   return 2'd3;
    return 2'd1;
  endfunction

  function automatic logic [3:0] m_ctl(int d);
    if (!m_run[d] || !start)       return C_HALT;
    if (m_bub[d] > 0)              return C_STALL;
    if (m_fl[d] > 0)               return C_FLUSH;
    if (hazard())                  return C_STALL;
    if (br)                        return C_FLUSH;
    return C_RUN;
  endfunction

  task automatic m_step(int d);
    logic [3:0] c;
    c = m_ctl(d);
    if (rst) begin
      m_run[d] = 0; m_bub[d] = 0; m_fl[d] = 0; m_sc[d] = 0; m_fc[d] = 0;
      return;
    end
`ifdef HAZARD_PERF_EN
    if (m_run[d] && start && c[0] && m_sc[d] < 64'hFFFF_FFFF) m_sc[d]++;
    if (c[1] && m_fc[d] < 64'hFFFF_FFFF) m_fc[d]++;
`endif
    if (!m_run[d])          m_run[d] = start;
    else if (!start)        begin m_run[d] = 0; m_bub[d] = 0; m_fl[d] = 0; end
    else if (m_bub[d] > 0)  m_bub[d]--;
    else if (m_fl[d] > 0)   m_fl[d]--;
    else if (hazard())      m_bub[d] = m_lstall[d] - 1;
    else if (br)            m_fl[d] = m_bflush[d] - 1;
  endtask

  // Compare counters of both DUTs and all of dut1 against the model, then advance the model.
  task automatic model_cycle(input string tag);
    check({tag, " dut1 state"}, 64'(st1), 64'(m_state(1)));
    check({tag, " dut1 ctl"}, 64'({pcw1, ifw1, fl1, bub1}), 64'(m_ctl(1)));
    check({tag, " dut0 stall_cnt"}, 64'(sc0), 64'(m_sc[0]));
    check({tag, " dut0 flush_cnt"}, 64'(fc0), 64'(m_fc[0]));
    check({tag, " dut1 stall_cnt"}, 64'(sc1), 64'(m_sc[1]));
    check({tag, " dut1 flush_cnt"}, 64'(fc1), 64'(m_fc[1]));
    m_step(0);
    m_step(1);
  endtask

  typedef struct {
    logic       rst, start;
    logic [4:0] rs, rt;
    logic       uses_rt, memrd;
    logic [4:0] ex_rt;
    logic       br;
    logic [1:0] st;
    logic [3:0] ctl;
  } vec_t;

  function automatic vec_t mk(logic r, logic s, logic [4:0] a, logic [4:0] b, logic u,
                              logic m, logic [4:0] e, logic bt, logic [1:0] st,
                              logic [3:0] ctl);
    vec_t v;
    v.rst = r; v.start = s; v.rs = a; v.rt = b; v.uses_rt = u; v.memrd = m;
    v.ex_rt = e; v.br = bt; v.st = st; v.ctl = ctl;
    return v;
  endfunction

  vec_t tbl [22];

  task automatic drive(logic r, logic s, logic [4:0] a, logic [4:0] b, logic u,
                       logic m, logic [4:0] e, logic bt);
    rst = r; start = s; rs = a; rt = b; uses_rt = u; memrd = m; ex_rt = e; br = bt;
  endtask

  initial begin
    // dut0 (3 stall cycles, 2 flush cycles) directed sequence from reset.
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 2'd0, C_HALT);
    tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 2'd0, C_HALT);
    tbl[2]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 2'd0, C_HALT);
    tbl[3]  = mk(0, 1, 1, 2, 0, 0, 0, 0, 2'd1, C_RUN);
    tbl[4]  = mk(0, 1, 8, 2, 0, 1, 8, 0, 2'd1, C_STALL);
    tbl[5]  = mk(0, 1, 8, 2, 0, 0, 8, 0, 2'd2, C_STALL);
    tbl[6]  = mk(0, 1, 8, 2, 0, 0, 8, 1, 2'd2, C_STALL);
    tbl[7]  = mk(0, 1, 1, 2, 0, 0, 0, 0, 2'd1, C_RUN);
    tbl[8]  = mk(0, 1, 3, 9, 0, 1, 9, 0, 2'd1, C_RUN);
    tbl[9]  = mk(0, 1, 0, 4, 1, 1, 0, 0, 2'd1, C_RUN);
    tbl[10] = mk(0, 1, 1, 2, 0, 0, 0, 1, 2'd1, C_FLUSH);
    tbl[11] = mk(0, 1, 7, 2, 0, 1, 7, 0, 2'd3, C_FLUSH);
    tbl[12] = mk(0, 1, 5, 2, 0, 1, 5, 1, 2'd1, C_STALL);
    tbl[13] = mk(0, 1, 5, 2, 0, 1, 5, 1, 2'd2, C_STALL);
    tbl[14] = mk(0, 0, 5, 2, 0, 1, 5, 0, 2'd2, C_HALT);
    tbl[15] = mk(0, 1, 5, 2, 0, 1, 5, 0, 2'd0, C_HALT);
    tbl[16] = mk(0, 1, 6, 9, 1, 1, 9, 0, 2'd1, C_STALL);
    tbl[17] = mk(0, 1, 6, 9, 1, 1, 9, 0, 2'd2, C_STALL);
    tbl[18] = mk(0, 1, 6, 9, 1, 1, 9, 0, 2'd2, C_STALL);
    tbl[19] = mk(0, 1, 1, 2, 0, 0, 0, 1, 2'd1, C_FLUSH);
    tbl[20] = mk(1, 1, 1, 2, 0, 0, 0, 0, 2'd3, C_FLUSH);
    tbl[21] = mk(0, 1, 1, 2, 0, 0, 0, 0, 2'd0, C_HALT);

    drive(1, 0, 0, 0, 0, 0, 0, 0);
    m_run = '{0, 0}; m_bub = '{0, 0}; m_fl = '{0, 0}; m_sc = '{0, 0}; m_fc = '{0, 0};

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].start, tbl[i].rs, tbl[i].rt, tbl[i].uses_rt,
            tbl[i].memrd, tbl[i].ex_rt, tbl[i].br);
      #1;
      check($sformatf("vec%0d state", i), 64'(st0), 64'(tbl[i].st));
      check($sformatf("vec%0d ctl", i), 64'({pcw0, ifw0, fl0, bub0}), 64'(tbl[i].ctl));
      model_cycle($sformatf("vec%0d", i));
    end

    // Single-bubble load-use on dut1: it stalls in RUN and never leaves it.
    @(negedge clk); drive(0, 1, 8, 0, 0, 1, 8, 0); #1;
    check("l1 hz state", 64'(st1), 64'(2'd1));
    check("l1 hz ctl", 64'({pcw1, ifw1, fl1, bub1}), 64'(C_STALL));
    model_cycle("l1 hz");
    @(negedge clk); drive(0, 1, 8, 0, 0, 0, 8, 0); #1;
    check("l1 resume state", 64'(st1), 64'(2'd1));
    check("l1 resume ctl", 64'({pcw1, ifw1, fl1, bub1}), 64'(C_RUN));
    model_cycle("l1 resume");

    // Randomized traffic: small register range so hazards are frequent.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 92,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
            $urandom_range(0, 99) < 40, 5'($urandom_range(0, 3)),
            $urandom_range(0, 99) < 25);
      #1;
      check("rnd dut0 state", 64'(st0), 64'(m_state(0)));
      check("rnd dut0 ctl", 64'({pcw0, ifw0, fl0, bub0}), 64'(m_ctl(0)));
      model_cycle("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
